// File: rtl/rename_stage.sv
// rename_stage: RAT-based register renaming with commit map, free-list interface and flush restore
module rename_stage #(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_rd_we,
  output logic                 fl_read,
  input  logic [TAG_WIDTH-1:0] fl_read_tag,
  input  logic                 fl_read_valid,
  output logic                 fl_return_valid,
  output logic [TAG_WIDTH-1:0] fl_return_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_WIDTH-1:0] out_prs1,
  output logic [TAG_WIDTH-1:0] out_prs2,
  output logic [TAG_WIDTH-1:0] out_prd,
  output logic [TAG_WIDTH-1:0] out_old_prd,
  output logic                 out_rd_we,
  input  logic                 commit_valid,
  input  logic                 commit_rd_we,
  input  logic [4:0]           commit_rd,
  input  logic [TAG_WIDTH-1:0] commit_prd,
  input  logic [TAG_WIDTH-1:0] commit_old_prd,
  input  logic                 flush
);
  if (NUM_PHYSICAL_REGS <= 32 || TAG_WIDTH != $clog2(NUM_PHYSICAL_REGS)) begin : g_bad_params
    $error("rename_stage: NUM_PHYSICAL_REGS must exceed 32 and TAG_WIDTH must be its clog2");
  end
  logic [TAG_WIDTH-1:0] spec_rat [32];
  logic [TAG_WIDTH-1:0] commit_rat [32];
  logic alloc, accept, commit_we;
  assign alloc = in_rd_we && in_rd != 5'd0;
  assign in_ready = !flush && (!out_valid || out_ready) && (!alloc || fl_read_valid);
  assign accept = in_valid && in_ready;
  assign fl_read = accept && alloc;
  assign commit_we = commit_valid && commit_rd_we && commit_rd != 5'd0;
  // Superseded tag goes back to the free list in the same cycle the instruction retires
  always_comb begin
    fl_return_valid = commit_we;
    fl_return_tag = commit_we ? commit_old_prd : '0;
  end
  // Committed map tracks retired destinations; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int i = 0; i < 32; i++) commit_rat[i] <= TAG_WIDTH'(i);
    else if (commit_we)
      commit_rat[commit_rd] <= commit_prd;
  end
  // Speculative map: flush copies the post-commit committed map, otherwise renames update rd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int i = 0; i < 32; i++) spec_rat[i] <= TAG_WIDTH'(i);
    else if (flush)
      for (int i = 0; i < 32; i++)
        spec_rat[i] <= (commit_we && commit_rd == 5'(i)) ? commit_prd : commit_rat[i];
    else if (accept && alloc)
      spec_rat[in_rd] <= fl_read_tag;
  end
  // Output register: loads on accept using the pre-update map, drains when dispatch takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prs1 <= '0;
      out_prs2 <= '0;
      out_prd <= '0;
      out_old_prd <= '0;
      out_rd_we <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_prs1 <= spec_rat[in_rs1];
      out_prs2 <= spec_rat[in_rs2];
      out_prd <= alloc ? fl_read_tag : '0;
      out_old_prd <= alloc ? spec_rat[in_rd] : '0;
      out_rd_we <= alloc;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed-vector self-checking bench for rename_stage
module tb_rename_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_rd_we;
  logic       fl_read;
  logic [5:0] fl_read_tag;
  logic       fl_read_valid;
  logic       fl_return_valid;
  logic [5:0] fl_return_tag;
  logic       out_valid, out_ready;
  logic [5:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic       out_rd_we;
  logic       commit_valid, commit_rd_we;
  logic [4:0] commit_rd;
  logic [5:0] commit_prd, commit_old_prd;
  logic       flush;
  int vectors = 0;
  int errs = 0;

  rename_stage #(.NUM_PHYSICAL_REGS(64), .TAG_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .fl_read(fl_read), .fl_read_tag(fl_read_tag), .fl_read_valid(fl_read_valid),
    .fl_return_valid(fl_return_valid), .fl_return_tag(fl_return_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rd_we(out_rd_we),
    .commit_valid(commit_valid), .commit_rd_we(commit_rd_we), .commit_rd(commit_rd),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic v, input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [5:0] tag);
    in_valid = v; in_rd = rd; in_rd_we = we; in_rs1 = rs1; in_rs2 = rs2; fl_read_tag = tag;
  endtask

  task automatic cmt(input logic v, input logic [4:0] rd, input logic [5:0] prd, input logic [5:0] old);
    commit_valid = v; commit_rd_we = 1'b1; commit_rd = rd; commit_prd = prd; commit_old_prd = old;
  endtask

  initial begin
    rst_n = 1'b0;
    ins(0, 0, 0, 0, 0, 0);
    cmt(0, 0, 0, 0);
    fl_read_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b0;
    tick(); tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_prd", out_prd, 0);
    chk("reset_out_old_prd", out_old_prd, 0);
    chk("reset_fl_return_valid", fl_return_valid, 0);
    rst_n = 1'b1;
    tick();
    // first rename: rd=5 rs1=5 rs2=0 gets tag 32
    ins(1, 5, 1, 5, 0, 32);
    #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_fl_read", fl_read, 1);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_prs1", out_prs1, 5);
    chk("t1_prs2", out_prs2, 0);
    chk("t1_prd", out_prd, 32);
    chk("t1_old_prd", out_old_prd, 5);
    chk("t1_rd_we", out_rd_we, 1);
    // back-to-back rename of rd=5 gets tag 33
    ins(1, 5, 1, 5, 0, 33);
    tick();
    chk("t2_prd", out_prd, 33);
    chk("t2_old_prd", out_old_prd, 32);
    chk("t2_prs1_pre_update", out_prs1, 32);
    ins(1, 0, 0, 5, 0, 0);
    tick();
    chk("t2_follow_prs1", out_prs1, 33);
    chk("t2_follow_prd", out_prd, 0);
    chk("t2_follow_old_prd", out_old_prd, 0);
    chk("t2_follow_rd_we", out_rd_we, 0);
    // free list empty: rd=0 proceeds, rd=3 stalls
    fl_read_valid = 1'b0;
    ins(1, 0, 1, 1, 2, 50);
    #1;
    chk("t3_x0_in_ready", in_ready, 1);
    chk("t3_x0_fl_read", fl_read, 0);
    tick();
    chk("t3_x0_out_valid", out_valid, 1);
    chk("t3_x0_rd_we", out_rd_we, 0);
    chk("t3_x0_prd", out_prd, 0);
    chk("t3_x0_prs1", out_prs1, 1);
    ins(1, 3, 1, 1, 2, 50);
    #1;
    chk("t3_rd3_in_ready", in_ready, 0);
    chk("t3_rd3_fl_read", fl_read, 0);
    tick();
    chk("t3_rd3_out_valid", out_valid, 0);
    fl_read_valid = 1'b1;
    // backpressure: rd=9 lands, then out_ready low for 3 cycles
    ins(1, 9, 1, 9, 0, 36);
    tick();
    chk("t4_prd", out_prd, 36);
    chk("t4_old_prd", out_old_prd, 9);
    out_ready = 1'b0;
    ins(1, 10, 1, 9, 0, 37);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_in_ready", in_ready, 0);
      chk("t4_stall_fl_read", fl_read, 0);
      chk("t4_stall_out_valid", out_valid, 1);
      chk("t4_stall_prd", out_prd, 36);
      chk("t4_stall_prs1", out_prs1, 9);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", in_ready, 1);
    chk("t4_release_fl_read", fl_read, 1);
    tick();
    chk("t4_release_prd", out_prd, 37);
    chk("t4_release_old_prd", out_old_prd, 10);
    chk("t4_release_prs1", out_prs1, 36);
    ins(1, 11, 1, 10, 0, 38);
    tick();
    chk("t4_next_prd", out_prd, 38);
    chk("t4_next_prs1", out_prs1, 37);
    ins(0, 0, 0, 0, 0, 0);
    // commit returns old tag combinationally; commit_rd=0 returns nothing
    cmt(1, 7, 40, 7);
    #1;
    chk("t5_return_valid", fl_return_valid, 1);
    chk("t5_return_tag", fl_return_tag, 7);
    tick();
    chk("t5_drain_out_valid", out_valid, 0);
    cmt(1, 0, 41, 9);
    #1;
    chk("t5_x0_return_valid", fl_return_valid, 0);
    chk("t5_x0_return_tag", fl_return_tag, 0);
    tick();
    cmt(0, 0, 0, 0);
    // rename 7->34 and 8->35, then commit 7->34 in the flush cycle
    ins(1, 7, 1, 0, 0, 34);
    tick();
    ins(1, 8, 1, 7, 0, 35);
    tick();
    chk("t6_prs1_7", out_prs1, 34);
    chk("t6_old_prd_8", out_old_prd, 8);
    ins(1, 12, 1, 0, 0, 39);
    cmt(1, 7, 34, 40);
    flush = 1'b1;
    #1;
    chk("t6_flush_in_ready", in_ready, 0);
    chk("t6_flush_fl_read", fl_read, 0);
    chk("t6_flush_return_tag", fl_return_tag, 40);
    tick();
    chk("t6_flush_out_valid", out_valid, 0);
    flush = 1'b0;
    cmt(0, 0, 0, 0);
    ins(1, 0, 0, 7, 8, 0);
    tick();
    chk("t6_restored_prs1", out_prs1, 34);
    chk("t6_restored_prs2", out_prs2, 8);
    ins(1, 0, 0, 5, 9, 0);
    tick();
    chk("t6_restored_r5", out_prs1, 5);
    chk("t6_restored_r9", out_prs2, 9);
    // asynchronous reset mid-stream
    ins(1, 4, 1, 7, 0, 41);
    tick();
    chk("t7_pre_reset_prd", out_prd, 41);
    chk("t7_pre_reset_prs1", out_prs1, 34);
    ins(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t7_async_out_valid", out_valid, 0);
    chk("t7_async_out_prd", out_prd, 0);
    #2;
    rst_n = 1'b1;
    tick();
    ins(1, 0, 0, 7, 4, 0);
    tick();
    chk("t7_identity_r7", out_prs1, 7);
    chk("t7_identity_r4", out_prs2, 4);
    ins(1, 0, 0, 5, 31, 0);
    tick();
    chk("t7_identity_r5", out_prs1, 5);
    chk("t7_identity_r31", out_prs2, 31);
    ins(0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ins(1, 0, 0, 7, 5, 0);
    tick();
    chk("t7_commit_identity_r7", out_prs1, 7);
    chk("t7_commit_identity_r5", out_prs2, 5);
    ins(0, 0, 0, 0, 0, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
